// File: rtl/spi_ctrl_tx.sv
`default_nettype none
// ============================================================================
// Module   : spi_ctrl_tx
// Purpose  : SPI mode-0 initiator that serialises 16-bit write frames
//            {rw, addr[6:0], data[7:0]} MSB first onto spi_sclk/spi_copi/spi_cs.
//            The sclk is slowed to CLK_DIV clk cycles per half-period so that a
//            peripheral sampling through 2-flop synchronisers sees clean edges.
// Revision : 1.0 - initial release
// ============================================================================
module spi_ctrl_tx #(
  parameter int CLK_DIV = 4,  // clk cycles per sclk half-period (>= 3)
  parameter int CS_LEAD = 4,  // clk cycles from cs fall to first sclk rise (>= 3)
  parameter int CS_GAP  = 4   // minimum clk cycles cs stays high between frames (>= 3)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       spi_sclk,
  output logic       spi_copi,
  output logic       spi_cs,
  output logic       busy,
  output logic       done
);

  // One shared down-counter times the lead, each sclk half-period and the gap,
  // so it is sized for the largest of the three.
  localparam int C_MAX_AB = (CLK_DIV > CS_LEAD) ? CLK_DIV : CS_LEAD;
  localparam int C_MAX    = (C_MAX_AB > CS_GAP) ? C_MAX_AB : CS_GAP;
  localparam int CW       = $clog2(C_MAX);

  localparam logic [CW-1:0] c_div_ld  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] c_lead_ld = CW'(CS_LEAD - 1);
  localparam logic [CW-1:0] c_gap_ld  = CW'(CS_GAP - 1);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_TRAIL = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_bit_idx;
  logic [15:0]     r_frame;

  logic            w_cnt_zero;
  logic [3:0]      w_idx_next;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_idx_next = r_bit_idx - 4'd1;

  // Frame sequencer: every SPI-facing output is a flop written only here, so
  // the pins can never glitch on combinational decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 4'd0;
      r_frame   <= 16'd0;
      spi_cs    <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_copi  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      // done is a single-cycle pulse; only the TRAIL exit raises it.
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // cmd_ready is high throughout IDLE, so valid alone means accept.
          if (cmd_valid) begin
            r_frame   <= {cmd_rw, cmd_addr, cmd_data};
            spi_cs    <= 1'b0;
            spi_copi  <= cmd_rw;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            r_cnt     <= c_lead_ld;
            r_bit_idx <= 4'd15;
            r_state   <= S_LEAD;
          end
        end

        S_LEAD: begin
          if (w_cnt_zero) begin
            spi_sclk <= 1'b1;
            r_cnt    <= c_div_ld;
            r_state  <= S_HIGH;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end

        S_HIGH: begin
          if (w_cnt_zero) begin
            spi_sclk <= 1'b0;
            r_cnt    <= c_div_ld;
            if (r_bit_idx == 4'd0) begin
              // Last bit: hold copi through a final low half-period.
              r_state <= S_TRAIL;
            end else begin
              // Mode 0: data moves on the falling sclk edge.
              spi_copi  <= r_frame[w_idx_next];
              r_bit_idx <= w_idx_next;
              r_state   <= S_LOW;
            end
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end

        S_LOW: begin
          if (w_cnt_zero) begin
            spi_sclk <= 1'b1;
            r_cnt    <= c_div_ld;
            r_state  <= S_HIGH;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end

        S_TRAIL: begin
          if (w_cnt_zero) begin
            spi_cs   <= 1'b1;
            spi_copi <= 1'b0;
            done     <= 1'b1;
            r_cnt    <= c_gap_ld;
            r_state  <= S_GAP;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end

        S_GAP: begin
          if (w_cnt_zero) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end

        default: begin
          // Unreachable encodings recover to a safe idle bus.
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          spi_cs    <= 1'b1;
          spi_sclk  <= 1'b0;
          spi_copi  <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
